// File: rtl/fetch_pc_unit_pkg.sv
// Shared definitions for the fetch stage: next-PC selector codes, the NOP
// encoding and the fetch FSM state encoding.
package fetch_pc_unit_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned WAIT_W  = 8;

  // Next-PC selector codes driven by decode
  localparam logic [SEL_W-1:0] PC_FROM_PC_PLUS_4 = 3'd0;
  localparam logic [SEL_W-1:0] PC_PLUS_JAL_IMM   = 3'd1;
  localparam logic [SEL_W-1:0] PC_PLUS_BRCH_IMM  = 3'd2;
  localparam logic [SEL_W-1:0] NEXT_PC_FROM_RF   = 3'd3;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_RETRY = 2'd2,
    S_HOLD  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_pc_unit_next_pc_calc.sv
// Combinational next-PC selector: sequential, JAL, conditional branch, JALR.
// Unknown or unused selector codes fall back to pc+4.
import fetch_pc_unit_pkg::*;

module next_pc_calc (
  input  logic [XLEN-1:0]  pc,
  input  logic [SEL_W-1:0] next_pc_sel,
  input  logic [XLEN-1:0]  jal_imm,
  input  logic [XLEN-1:0]  brch_imm,
  input  logic [XLEN-1:0]  rf_target,
  input  logic             alu_zero,
  output logic [XLEN-1:0]  next_pc
);

  logic [XLEN-1:0] pc_plus_4;

  assign pc_plus_4 = pc + XLEN'(4);

  // Select the next PC; all adds wrap modulo 2^32
  always_comb begin
    next_pc = pc_plus_4;
    case (next_pc_sel)
      PC_FROM_PC_PLUS_4: next_pc = pc_plus_4;
      PC_PLUS_JAL_IMM:   next_pc = pc + jal_imm;
      PC_PLUS_BRCH_IMM:  next_pc = alu_zero ? (pc + brch_imm) : pc_plus_4;
      NEXT_PC_FROM_RF:   next_pc = {rf_target[XLEN-1:1], 1'b0};
      default:           next_pc = pc_plus_4;
    endcase
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Non-pipelined fetch stage: holds the PC, fetches one instruction over the
// imem request/valid handshake, holds it for decode/execute and advances the
// PC on ex_done. A fetch that gets no response within TIMEOUT cycles drops
// imem_req for one cycle and re-issues.
// Optional: FETCH_MISALIGN_CHECK_EN redirects a misaligned next PC to TRAP_PC
// with a one-cycle misalign_trap pulse; otherwise the low PC bits are cleared.
import fetch_pc_unit_pkg::*;

module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
`ifdef FETCH_MISALIGN_CHECK_EN
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100,
`endif
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_rvalid,
  input  logic [XLEN-1:0]  imem_rdata,
  output logic [XLEN-1:0]  inst_encoding,
  output logic             inst_valid,
  input  logic [SEL_W-1:0] next_pc_sel,
  input  logic [XLEN-1:0]  jal_imm,
  input  logic [XLEN-1:0]  brch_imm,
  input  logic [XLEN-1:0]  rf_target,
  input  logic             alu_zero,
  input  logic             ex_done,
  output logic [XLEN-1:0]  pc,
  output logic             misalign_trap
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  fetch_state_e      state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [XLEN-1:0]   inst_q, inst_d;
  logic              valid_q, valid_d;
  logic              trap_q, trap_d;
  logic [XLEN-1:0]   next_pc;
  logic [XLEN-1:0]   load_pc;
  logic              misaligned;

  next_pc_calc u_next_pc_calc (
    .pc          (pc_q),
    .next_pc_sel (next_pc_sel),
    .jal_imm     (jal_imm),
    .brch_imm    (brch_imm),
    .rf_target   (rf_target),
    .alu_zero    (alu_zero),
    .next_pc     (next_pc)
  );

  // PC value loaded on ex_done, after alignment handling
`ifdef FETCH_MISALIGN_CHECK_EN
  assign misaligned = |next_pc[1:0];
  assign load_pc    = misaligned ? TRAP_PC : next_pc;
`else
  assign misaligned = 1'b0;
  assign load_pc    = next_pc & ~XLEN'(3);
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
      wait_q  <= '0;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      wait_q  <= wait_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
      trap_q  <= trap_d;
    end
  end

  // Next-state and next-register logic; responses and ex_done act only in
  // the state where they are legal
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    wait_d  = '0;
    inst_d  = inst_q;
    valid_d = valid_q;
    trap_d  = 1'b0;
    case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        if (imem_rvalid) begin
          inst_d  = imem_rdata;
          valid_d = 1'b1;
          state_d = S_HOLD;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_RETRY;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_RETRY: state_d = S_FETCH;
      S_HOLD: begin
        if (ex_done) begin
          pc_d    = load_pc;
          valid_d = 1'b0;
          trap_d  = misaligned;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  assign imem_req      = (state_q == S_FETCH);
  assign imem_addr     = pc_q;
  assign pc            = pc_q;
  assign inst_encoding = inst_q;
  assign inst_valid    = valid_q;
  assign misalign_trap = trap_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Self-checking bench for fetch_pc_unit. Instruction words are queued when a
// response is driven and compared when inst_valid rises.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst_encoding;
  logic        inst_valid;
  logic [2:0]  next_pc_sel = '0;
  logic [31:0] jal_imm = '0;
  logic [31:0] brch_imm = '0;
  logic [31:0] rf_target = '0;
  logic        alu_zero = 1'b0;
  logic        ex_done = 1'b0;
  logic [31:0] pc;
  logic        misalign_trap;

  int unsigned total = 0;
  int unsigned bad = 0;
  logic [31:0] cur_pc = 32'h0;
  logic [31:0] exp_q[$];

  fetch_pc_unit dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .inst_encoding (inst_encoding),
    .inst_valid    (inst_valid),
    .next_pc_sel   (next_pc_sel),
    .jal_imm       (jal_imm),
    .brch_imm      (brch_imm),
    .rf_target     (rf_target),
    .alu_zero      (alu_zero),
    .ex_done       (ex_done),
    .pc            (pc),
    .misalign_trap (misalign_trap)
  );

  always #5 clk = ~clk;

  // Reference next PC: {trap, pc}
  function automatic logic [32:0] model_pc(input logic [31:0] p, input logic [2:0] sel,
                                           input logic [31:0] ji, input logic [31:0] bi,
                                           input logic [31:0] rt, input logic z);
    logic [31:0] raw;
    case (sel)
      3'd1:    raw = p + ji;
      3'd2:    raw = z ? p + bi : p + 32'd4;
      3'd3:    raw = rt & 32'hFFFF_FFFE;
      default: raw = p + 32'd4;
    endcase
`ifdef FETCH_MISALIGN_CHECK_EN
    if (raw[1:0] != 2'b00) return {1'b1, 32'h0000_0100};
    return {1'b0, raw};
`else
    return {1'b0, raw & 32'hFFFF_FFFC};
`endif
  endfunction

  task automatic do_fetch(input logic [31:0] word, input int delay);
    logic [31:0] exp_w;
    int n = 0;
    while (!imem_req && n < 40) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!imem_req) begin
      bad++;
      $display("FAIL fetch_req_wait: imem_req=%0b required=1 within 40 cycles", imem_req);
      return;
    end
    total++;
    if (imem_addr !== cur_pc) begin
      bad++;
      $display("FAIL fetch_addr: got=%h exp=%h", imem_addr, cur_pc);
    end
    repeat (delay) @(negedge clk);
    imem_rvalid = 1'b1;
    imem_rdata  = word;
    exp_q.push_back(word);
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata  = 32'hDEAD_BEEF;
    exp_w = exp_q.pop_front();
    total++;
    if (inst_valid !== 1'b1 || inst_encoding !== exp_w) begin
      bad++;
      $display("FAIL fetch_inst: valid=%0b enc=%h exp valid=1 enc=%h", inst_valid, inst_encoding, exp_w);
    end
  endtask

  task automatic do_ex(input logic [2:0] sel, input logic [31:0] ji, input logic [31:0] bi,
                       input logic [31:0] rt, input logic z,
                       input logic [31:0] exp_pc, input logic exp_trap);
    next_pc_sel = sel;
    jal_imm     = ji;
    brch_imm    = bi;
    rf_target   = rt;
    alu_zero    = z;
    ex_done     = 1'b1;
    @(negedge clk);
    ex_done = 1'b0;
    total++;
    if (pc !== exp_pc || misalign_trap !== exp_trap || inst_valid !== 1'b0 || imem_req !== 1'b1) begin
      bad++;
      $display("FAIL ex_advance sel=%0d: pc=%h trap=%0b valid=%0b req=%0b exp pc=%h trap=%0b valid=0 req=1",
               sel, pc, misalign_trap, inst_valid, imem_req, exp_pc, exp_trap);
    end
    cur_pc = exp_pc;
  endtask

  task automatic goto_pc(input logic [31:0] target);
    do_fetch(32'h0000_0013, 0);
    do_ex(3'd3, '0, '0, target, 1'b0, target, 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (pc !== 32'h0 || imem_req !== 1'b0 || inst_valid !== 1'b0 ||
        inst_encoding !== 32'h0000_0013 || misalign_trap !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: pc=%h req=%0b valid=%0b enc=%h trap=%0b exp 0/0/0/00000013/0",
               pc, imem_req, inst_valid, inst_encoding, misalign_trap);
    end
    rst = 1'b0;
    cur_pc = 32'h0;
  endtask

  task automatic test_first_fetch();
    do_fetch(32'h0050_0093, 2);
    do_ex(3'd0, '0, '0, '0, 1'b0, 32'h4, 1'b0);
  endtask

  task automatic test_jal_wrap();
    goto_pc(32'h40);
    do_fetch(32'h1111_0001, 1);
    do_ex(3'd1, 32'hFFFF_FFF0, '0, '0, 1'b0, 32'h30, 1'b0);
    goto_pc(32'hFFFF_FFFC);
    do_fetch(32'h1111_0002, 0);
    do_ex(3'd0, '0, '0, '0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic test_branch();
    goto_pc(32'h80);
    do_fetch(32'h2222_0001, 1);
    do_ex(3'd2, '0, 32'h20, '0, 1'b1, 32'hA0, 1'b0);
    goto_pc(32'h80);
    do_fetch(32'h2222_0002, 2);
    do_ex(3'd2, '0, 32'h20, '0, 1'b0, 32'h84, 1'b0);
  endtask

  task automatic test_rf_and_illegal();
    do_fetch(32'h3333_0001, 0);
    do_ex(3'd3, '0, '0, 32'h1235, 1'b0, 32'h1234, 1'b0);
    do_fetch(32'h3333_0002, 1);
    do_ex(3'd7, 32'h40, 32'h40, 32'h40, 1'b1, 32'h1238, 1'b0);
  endtask

  // Starts on the first cycle of a fresh fetch
  task automatic test_timeout();
    int n = 0;
    for (int i = 0; i < 300 && imem_req; i++) begin
      n++;
      ex_done     = (i == 3);
      next_pc_sel = 3'd1;
      jal_imm     = 32'h100;
      @(negedge clk);
    end
    ex_done = 1'b0;
    total++;
    if (n != 16 || imem_req !== 1'b0) begin
      bad++;
      $display("FAIL timeout_req_drop: req_high_cycles=%0d req=%0b exp 16 cycles then req=0", n, imem_req);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0001;
    @(negedge clk);
    imem_rvalid = 1'b0;
    total++;
    if (imem_req !== 1'b1 || imem_addr !== cur_pc || inst_valid !== 1'b0 || pc !== cur_pc) begin
      bad++;
      $display("FAIL timeout_reissue: req=%0b addr=%h valid=%0b pc=%h exp req=1 addr=%h valid=0",
               imem_req, imem_addr, inst_valid, pc, cur_pc);
    end
    do_fetch(32'h4444_0001, 1);
    do_ex(3'd0, '0, '0, '0, 1'b0, cur_pc + 32'd4, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [32:0] m;
    logic [2:0]  s;
    logic [31:0] ji, bi, rt;
    logic        z;
    for (int i = 0; i < 8; i++) begin
      s  = 3'($urandom_range(0, 7));
      ji = $urandom & 32'h0000_0FFF;
      bi = $urandom & 32'h0000_0FFF;
      rt = $urandom;
      z  = 1'($urandom_range(0, 1));
      m  = model_pc(cur_pc, s, ji, bi, rt, z);
      do_fetch($urandom, 0);
      do_ex(s, ji, bi, rt, z, m[31:0], m[32]);
      if (m[32]) @(negedge clk);
    end
  endtask

  task automatic test_misalign();
    goto_pc(32'h0);
    do_fetch(32'h5555_0001, 0);
`ifdef FETCH_MISALIGN_CHECK_EN
    do_ex(3'd1, 32'h6, '0, '0, 1'b0, 32'h100, 1'b1);
`else
    do_ex(3'd1, 32'h6, '0, '0, 1'b0, 32'h4, 1'b0);
`endif
    @(negedge clk);
    total++;
    if (misalign_trap !== 1'b0) begin
      bad++;
      $display("FAIL trap_one_cycle: misalign_trap=%0b exp=0", misalign_trap);
    end
  endtask

  task automatic test_reset_in_hold();
    goto_pc(32'h200);
    do_fetch(32'h6666_0001, 1);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (pc !== 32'h0 || inst_valid !== 1'b0 || imem_req !== 1'b0 || inst_encoding !== 32'h0000_0013) begin
      bad++;
      $display("FAIL reset_hold: pc=%h valid=%0b req=%0b enc=%h exp 0/0/0/00000013",
               pc, inst_valid, imem_req, inst_encoding);
    end
    rst = 1'b0;
    cur_pc = 32'h0;
    imem_rvalid = 1'b1;
    imem_rdata  = 32'hBAD0_0002;
    @(negedge clk);
    imem_rvalid = 1'b0;
    total++;
    if (inst_valid !== 1'b0 || inst_encoding !== 32'h0000_0013 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      bad++;
      $display("FAIL late_rvalid_ignored: valid=%0b enc=%h req=%0b addr=%h exp 0/00000013/1/0",
               inst_valid, inst_encoding, imem_req, imem_addr);
    end
    do_fetch(32'h6666_0002, 0);
    do_ex(3'd0, '0, '0, '0, 1'b0, 32'h4, 1'b0);
  endtask

  initial begin
    test_reset();
    test_first_fetch();
    test_jal_wrap();
    test_branch();
    test_rf_and_illegal();
    test_timeout();
    test_back_to_back();
    test_misalign();
    test_reset_in_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
